shifter_arbiter: RTL

Shares one combinational `shifter` instance (sign-magnitude left shift, N-bit) between two requesters using round-robin arbitration. Each requester sees a valid/ready request channel and a valid/ready response channel. Operands are captured, the shifter result is registered, and the response is held until the owning requester accepts it. The block sits between the two ALU front-end issue ports and the shared shift datapath. It also keeps saturating error and overflow event counters for debug.

---
 rtl/shifter_arbiter_pkg.sv | 15 +
 rtl/shifter_arbiter_if.sv | 36 +++
 rtl/shifter_arbiter_shifter.sv | 28 ++
 rtl/shifter_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/shifter_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Imported by the interface, the top level and the bench.
package shifter_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage : shifter_arb_pkg

// File: rtl/shifter_arbiter_if.sv
// Request/response bundle between the two ALU issue ports and the shift arbiter.
// The slave modport is the arbiter; the master modport is the issuing side.
interface shifter_arbiter_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  import shifter_arb_pkg::*;

  logic [NUM_REQ-1:0] i_req_vld;
  logic [N-1:0]       i_a0;
  logic [N-1:0]       i_b0;
  logic [N-1:0]       i_a1;
  logic [N-1:0]       i_b1;
  logic [NUM_REQ-1:0] o_req_rdy;
  logic [NUM_REQ-1:0] o_rsp_vld;
  logic [N-1:0]       o_rsp_out;
  logic               o_rsp_err;
  logic               o_rsp_ovf;
  logic [NUM_REQ-1:0] i_rsp_rdy;
  logic               o_busy;
  logic [CNT_W-1:0]   o_cnt_err;
  logic [CNT_W-1:0]   o_cnt_ovf;

  modport slave (
    input  i_req_vld, i_a0, i_b0, i_a1, i_b1, i_rsp_rdy,
    output o_req_rdy, o_rsp_vld, o_rsp_out, o_rsp_err, o_rsp_ovf,
           o_busy, o_cnt_err, o_cnt_ovf
  );

  modport master (
    output i_req_vld, i_a0, i_b0, i_a1, i_b1, i_rsp_rdy,
    input  o_req_rdy, o_rsp_vld, o_rsp_out, o_rsp_err, o_rsp_ovf,
           o_busy, o_cnt_err, o_cnt_ovf
  );

endinterface : shifter_arbiter_if

// File: rtl/shifter_arbiter_shifter.sv
// Combinational sign-magnitude left shifter: sign passes through, the magnitude
// is shifted in a double-width field so any lost bits can be flagged as overflow.
module shifter #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] out_o,
  output logic         err_o,
  output logic         ovf_o
);

  logic [2*N-1:0] shifted;

  always_comb begin
    shifted = {{(N + 1){1'b0}}, a_i[N-2:0]} << b_i[N-2:0];
    err_o   = b_i[N-1];
    // A negative shift count is rejected outright rather than shifting right.
    if (err_o) begin
      out_o = '0;
      ovf_o = 1'b0;
    end else begin
      out_o = {a_i[N-1], shifted[N-2:0]};
      ovf_o = |shifted[2*N-1:N-1];
    end
  end

endmodule : shifter

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters, with a
// registered, held response and saturating error/overflow debug counters.
module shifter_arbiter
  import shifter_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  shifter_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_q, state_d;
  req_id_t          owner_q, owner_d;
  req_id_t          ptr_q, ptr_d;
  logic [N-1:0]     opA_q, opA_d;
  logic [N-1:0]     opB_q, opB_d;
  logic [N-1:0]     rspOut_q, rspOut_d;
  logic             rspErr_q, rspErr_d;
  logic             rspOvf_q, rspOvf_d;
  logic [CNT_W-1:0] cntErr_q, cntErr_d;
  logic [CNT_W-1:0] cntOvf_q, cntOvf_d;

  logic             grantVld;
  req_id_t          grantId;
  logic             rspDone;
  logic [N-1:0]     shOut;
  logic             shErr;
  logic             shOvf;

  shifter #(.N(N)) u_shifter (
    .a_i   (opA_q),
    .b_i   (opB_q),
    .out_o (shOut),
    .err_o (shErr),
    .ovf_o (shOvf)
  );

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grantVld = 1'b0;
    grantId  = ptr_q;
    if (state_q == ST_IDLE) begin
      case (bus.i_req_vld)
        2'b01: begin
          grantVld = 1'b1;
          grantId  = 1'b0;
        end
        2'b10: begin
          grantVld = 1'b1;
          grantId  = 1'b1;
        end
        2'b11: begin
          grantVld = 1'b1;
          grantId  = ptr_q;
        end
        default: begin
          grantVld = 1'b0;
          grantId  = ptr_q;
        end
      endcase
    end
  end

  assign rspDone = (state_q == ST_RESP) && bus.i_rsp_rdy[owner_q];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    rspOut_d = rspOut_q;
    rspErr_d = rspErr_q;
    rspOvf_d = rspOvf_q;
    cntErr_d = cntErr_q;
    cntOvf_d = cntOvf_q;
    case (state_q)
      ST_IDLE: begin
        if (grantVld) begin
          owner_d = grantId;
          opA_d   = grantId ? bus.i_a1 : bus.i_a0;
          opB_d   = grantId ? bus.i_b1 : bus.i_b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rspOut_d = shOut;
        rspErr_d = shErr;
        rspOvf_d = shOvf;
        if (shErr && (cntErr_q != '1)) begin
          cntErr_d = cntErr_q + CNT_W'(1);
        end
        if (shOvf && (cntOvf_q != '1)) begin
          cntOvf_d = cntOvf_q + CNT_W'(1);
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Fairness: whoever just finished yields the next tie to the other side.
        if (rspDone) begin
          ptr_d   = ~owner_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      rspOut_q <= '0;
      rspErr_q <= 1'b0;
      rspOvf_q <= 1'b0;
      cntErr_q <= '0;
      cntOvf_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      rspOut_q <= rspOut_d;
      rspErr_q <= rspErr_d;
      rspOvf_q <= rspOvf_d;
      cntErr_q <= cntErr_d;
      cntOvf_q <= cntOvf_d;
    end
  end

  always_comb begin
    bus.o_req_rdy = '0;
    bus.o_rsp_vld = '0;
    if (grantVld) begin
      bus.o_req_rdy[grantId] = 1'b1;
    end
    if (state_q == ST_RESP) begin
      bus.o_rsp_vld[owner_q] = 1'b1;
    end
  end

  assign bus.o_rsp_out = rspOut_q;
  assign bus.o_rsp_err = rspErr_q;
  assign bus.o_rsp_ovf = rspOvf_q;
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_cnt_err = cntErr_q;
  assign bus.o_cnt_ovf = cntOvf_q;

endmodule : shifter_arbiter
